instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/retire_counter.sv | 21 ++
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the instruction sequencer
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } state_t;

    localparam logic [2:0] IT_ALU   = 3'b000;
    localparam logic [2:0] IT_STORE = 3'b001;
    localparam logic [2:0] IT_LOAD  = 3'b010;
    localparam logic [2:0] IT_JCOND = 3'b011;
    localparam logic [2:0] IT_BCOND = 3'b100;
    localparam logic [2:0] IT_JAL   = 3'b101;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_DISP = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [7:0] ALU_CMP = 8'b00001011;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - free-running retired-instruction counter, wraps at 2^32
module retire_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 32'd0;
        end else if (inc) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle control FSM for a simple CPU datapath
// Optional retired_cnt output enabled by INSTR_SEQ_PERF_CNT_EN.
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  instr_type,
    input  logic [7:0]  alu_op,
    input  logic        cond_true,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        flag_we,
    output logic        mem_we,
    output logic        addr_sel,
`ifdef INSTR_SEQ_PERF_CNT_EN
    output logic [31:0] retired_cnt,
`endif
    output logic [2:0]  state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = ST_FETCH;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_INC;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        flag_we  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (instr_type == IT_STORE || instr_type == IT_LOAD) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                pc_en   = 1'b1;
                state_d = ST_FETCH;
                case (instr_type)
                    IT_ALU: begin
                        flag_we = 1'b1;
                        reg_we  = (alu_op != ALU_CMP);
                    end
                    IT_JCOND: pc_sel = cond_true ? PC_REG : PC_INC;
                    IT_BCOND: pc_sel = cond_true ? PC_DISP : PC_INC;
                    IT_JAL: begin
                        reg_we = 1'b1;
                        wb_sel = WB_LINK;
                        pc_sel = PC_REG;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                if (instr_type == IT_STORE) begin
                    mem_we  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = WB_MEM;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset masks the strobes combinationally so nothing fires in the reset cycle itself.
        if (!reset) begin
            ir_en    = 1'b0;
            pc_en    = 1'b0;
            pc_sel   = PC_INC;
            reg_we   = 1'b0;
            wb_sel   = WB_ALU;
            flag_we  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
        end
    end

    assign state = reset ? state_q : ST_FETCH;

`ifdef INSTR_SEQ_PERF_CNT_EN
    retire_counter u_retire (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_en),
        .count (retired_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [2:0]  instr_type;
    logic [7:0]  alu_op;
    logic        cond_true;
    logic        ir_en, pc_en, reg_we, flag_we, mem_we, addr_sel;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
`ifdef INSTR_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instr_type (instr_type),
        .alu_op     (alu_op),
        .cond_true  (cond_true),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .flag_we    (flag_we),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
`ifdef INSTR_SEQ_PERF_CNT_EN
        .retired_cnt(retired_cnt),
`endif
        .state      (state)
    );

    // Order: ir_en pc_en pc_sel reg_we wb_sel flag_we mem_we addr_sel state
    function automatic logic [12:0] pk(input logic ir, input logic pce, input logic [1:0] pcs,
                                       input logic rwe, input logic [1:0] wbs, input logic fwe,
                                       input logic mwe, input logic as, input logic [2:0] st);
        return {ir, pce, pcs, rwe, wbs, fwe, mwe, as, st};
    endfunction

    localparam logic [12:0] E_IDLE  = 13'b1_0_00_0_00_0_0_0_000 & 13'b0_1_11_1_11_1_1_1_111;
    localparam logic [12:0] E_FETCH = 13'b1_0_00_0_00_0_0_0_000;
    localparam logic [12:0] E_DEC   = 13'b0_0_00_0_00_0_0_0_001;

    task automatic step(input logic rst, input logic rn, input logic [2:0] it, input logic [7:0] op,
                        input logic cd, input logic [12:0] e, input string nm);
        sb_t s;
        @(posedge clk);
        #1;
        reset      = rst;
        run        = rn;
        instr_type = it;
        alu_op     = op;
        cond_true  = cd;
        s.exp  = e;
        s.name = nm;
        sbq.push_back(s);
    endtask

    task automatic fd(input logic [2:0] it, input logic [7:0] op, input logic cd, input string nm);
        step(1, 1, it, op, cd, E_FETCH, {nm, "_fetch"});
        step(1, 1, it, op, cd, E_DEC,   {nm, "_decode"});
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            sb_t s;
            logic [12:0] act;
            s   = sbq.pop_front();
            act = {ir_en, pc_en, pc_sel, reg_we, wb_sel, flag_we, mem_we, addr_sel, state};
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b required %b", s.name, act, s.exp);
            end
        end
    end

    initial begin
        reset = 0; run = 1; instr_type = 3'b000; alu_op = 8'h00; cond_true = 0;

        step(0, 1, 3'b000, 8'h01, 0, E_IDLE, "reset0");
        step(0, 1, 3'b000, 8'h01, 0, E_IDLE, "reset1");

        fd(3'b000, 8'h01, 0, "add");
        step(1, 1, 3'b000, 8'h01, 0, pk(0,1,2'b00,1,2'b00,1,0,0,3'd2), "add_exec");

        fd(3'b000, 8'h0B, 0, "cmp");
        step(1, 1, 3'b000, 8'h0B, 0, pk(0,1,2'b00,0,2'b00,1,0,0,3'd2), "cmp_exec");

        fd(3'b010, 8'h00, 0, "load");
        step(1, 1, 3'b010, 8'h00, 0, pk(0,0,2'b00,0,2'b00,0,0,1,3'd3), "load_mem");
        step(1, 1, 3'b010, 8'h00, 0, pk(0,1,2'b00,1,2'b01,0,0,0,3'd4), "load_wb");

        fd(3'b001, 8'h00, 0, "store");
        step(1, 1, 3'b001, 8'h00, 0, pk(0,1,2'b00,0,2'b00,0,1,1,3'd3), "store_mem");

        fd(3'b011, 8'h00, 1, "jc_t");
        step(1, 1, 3'b011, 8'h00, 1, pk(0,1,2'b10,0,2'b00,0,0,0,3'd2), "jc_t_exec");
        fd(3'b011, 8'h00, 0, "jc_f");
        step(1, 1, 3'b011, 8'h00, 0, pk(0,1,2'b00,0,2'b00,0,0,0,3'd2), "jc_f_exec");

        fd(3'b100, 8'h00, 1, "bc_t");
        step(1, 1, 3'b100, 8'h00, 1, pk(0,1,2'b01,0,2'b00,0,0,0,3'd2), "bc_t_exec");
        fd(3'b100, 8'h00, 0, "bc_f");
        step(1, 1, 3'b100, 8'h00, 0, pk(0,1,2'b00,0,2'b00,0,0,0,3'd2), "bc_f_exec");

        fd(3'b101, 8'h00, 0, "jal");
        step(1, 1, 3'b101, 8'h00, 0, pk(0,1,2'b10,1,2'b10,0,0,0,3'd2), "jal_exec");

        fd(3'b110, 8'h00, 1, "ill");
        step(1, 1, 3'b110, 8'h00, 1, pk(0,1,2'b00,0,2'b00,0,0,0,3'd2), "ill_exec");

        step(1, 0, 3'b000, 8'h01, 0, E_IDLE, "hold0");
        step(1, 0, 3'b000, 8'h01, 0, E_IDLE, "hold1");

        step(1, 1, 3'b000, 8'h01, 0, E_FETCH, "midrun_fetch");
        step(1, 0, 3'b000, 8'h01, 0, E_DEC,   "midrun_decode");
        step(1, 0, 3'b000, 8'h01, 0, pk(0,1,2'b00,1,2'b00,1,0,0,3'd2), "midrun_exec");
        step(1, 0, 3'b000, 8'h01, 0, E_IDLE, "midrun_hold");

        fd(3'b001, 8'h00, 0, "strst");
        step(0, 1, 3'b001, 8'h00, 0, E_IDLE, "strst_mem_reset");
        step(1, 1, 3'b000, 8'h01, 0, E_FETCH, "strst_refetch");
        step(1, 1, 3'b000, 8'h01, 0, E_DEC,   "strst_decode");
        step(1, 1, 3'b000, 8'h01, 0, pk(0,1,2'b00,1,2'b00,1,0,0,3'd2), "strst_exec");

`ifdef INSTR_SEQ_PERF_CNT_EN
        step(0, 1, 3'b000, 8'h01, 0, E_IDLE, "cnt_reset");
        for (int i = 0; i < 5; i++) begin
            fd(3'b000, 8'h01, 0, "cnt_alu");
            step(1, 1, 3'b000, 8'h01, 0, pk(0,1,2'b00,1,2'b00,1,0,0,3'd2), "cnt_alu_exec");
        end
        step(1, 0, 3'b000, 8'h01, 0, E_IDLE, "cnt_hold");
        checks++;
        if (retired_cnt !== 32'd5) begin
            errors++;
            $display("FAIL cnt_five: got %0d required 5", retired_cnt);
        end
        force dut.u_retire.count_q = 32'hFFFF_FFFF;
        fd(3'b000, 8'h01, 0, "wrap");
        release dut.u_retire.count_q;
        step(1, 1, 3'b000, 8'h01, 0, pk(0,1,2'b00,1,2'b00,1,0,0,3'd2), "wrap_exec");
        step(1, 0, 3'b000, 8'h01, 0, E_IDLE, "wrap_hold");
        checks++;
        if (retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_wrap: got %h required 00000000", retired_cnt);
        end
`endif

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
